nf10_param_output_queues: RTL and testbench

Parametrised output-queue stage placed after the output-port lookup in the datapath. It accepts one AXI4-Stream packet flow and fans it out to NUM_QUEUES independent BRAM FIFOs, one per egress port, selected by the one-hot destination field of tuser. Multicast packets are written to all selected queues at once. A packet is admitted or dropped whole at its first beat, so the input never stalls on a busy egress.

---
 rtl/nf10_oq_pkg.sv | 19 +
 rtl/nf10_oq_fifo.sv | 82 ++++++++
 rtl/nf10_param_output_queues.sv | 154 +++++++++++++++
 tb/tb_nf10_param_output_queues.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_oq_pkg.sv
// Shared types and constants for the parametrised output-queue stage.
// Holds the ingress FSM encoding, the default destination-field position and counter sizing.
package nf10_oq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DROP  = 2'd2
   } oq_state_e;

   localparam int unsigned OQ_DST_POS = 24;
   localparam int unsigned OQ_CNT_W   = 32;

   // Saturating increment for the statistics counters.
   function automatic logic [OQ_CNT_W-1:0] oq_sat_inc(input logic [OQ_CNT_W-1:0] v);
      return (&v) ? v : v + OQ_CNT_W'(1);
   endfunction

endpackage

// File: rtl/nf10_oq_fifo.sv
// First-word-fall-through FIFO built from a synchronous-read memory plus one output register.
// An empty FIFO forwards the incoming word straight into the output register.
module nf10_oq_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 512,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_valid,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_vld;

   logic w_push;
   logic w_pop;
   logic w_mem_empty;
   logic w_load;
   logic w_bypass;
   logic w_mem_wr;

   // r_count covers the memory and the output register together.
   assign w_push      = i_wr_en && (r_count != CW'(DEPTH));
   assign w_pop       = r_dout_vld && i_rd_en;
   assign w_mem_empty = (r_count == CW'(r_dout_vld));
   assign w_load      = !r_dout_vld || w_pop;
   assign w_bypass    = w_load && w_mem_empty && w_push;
   assign w_mem_wr    = w_push && !w_bypass;

   always_ff @(posedge i_clk) begin
      if (w_mem_wr) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_dout     <= '0;
         r_dout_vld <= 1'b0;
      end else begin
         if (w_mem_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_load) begin
            if (!w_mem_empty) begin
               r_dout     <= r_mem[r_rd_ptr];
               r_rd_ptr   <= r_rd_ptr + AW'(1);
               r_dout_vld <= 1'b1;
            end else if (w_push) begin
               r_dout     <= i_din;
               r_dout_vld <= 1'b1;
            end else begin
               r_dout_vld <= 1'b0;
            end
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dout  = r_dout;
   assign o_valid = r_dout_vld;
   assign o_count = r_count;

endmodule

// File: rtl/nf10_param_output_queues.sv
// One AXI4-Stream ingress fanned out to NUM_QUEUES FWFT queues by the one-hot tuser destination.
// Packets are admitted or dropped whole at the first beat; OQ_STATS_EN adds per-queue counters.
module nf10_param_output_queues
   import nf10_oq_pkg::*;
#(
   parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned NUM_QUEUES           = 5,
   parameter int unsigned QUEUE_DEPTH          = 512,
   parameter int unsigned MAX_PKT_WORDS        = 48,
   parameter int unsigned DST_POS              = OQ_DST_POS
) (
   input  logic                                          axi_aclk,
   input  logic                                          axi_resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]                s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]              s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]               s_axis_tuser,
   input  logic                                          s_axis_tvalid,
   input  logic                                          s_axis_tlast,
   output logic                                          s_axis_tready,
   output logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
   output logic [NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic [NUM_QUEUES-1:0]                         m_axis_tvalid,
   input  logic [NUM_QUEUES-1:0]                         m_axis_tready,
   output logic [NUM_QUEUES-1:0]                         m_axis_tlast
`ifdef OQ_STATS_EN
   ,
   output logic [NUM_QUEUES*OQ_CNT_W-1:0]                pkt_drop_cnt,
   output logic [NUM_QUEUES*OQ_CNT_W-1:0]                pkt_enq_cnt
`endif
);

   localparam int unsigned DW = C_M_AXIS_DATA_WIDTH;
   localparam int unsigned SW = C_M_AXIS_DATA_WIDTH / 8;
   localparam int unsigned UW = C_M_AXIS_TUSER_WIDTH;
   localparam int unsigned WW = DW + SW + UW + 1;
   localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

   oq_state_e               r_state;
   logic [NUM_QUEUES-1:0]   r_sel;

   logic [NUM_QUEUES-1:0]   w_dst;
   logic [NUM_QUEUES-1:0]   w_room;
   logic [NUM_QUEUES-1:0]   w_wr_en;
   logic [NUM_QUEUES-1:0]   w_valid;
   logic                    w_admit;
   logic                    w_first;
   logic [WW-1:0]           w_din;
   logic [WW-1:0]           w_dout  [NUM_QUEUES];
   logic [CW-1:0]           w_count [NUM_QUEUES];

   // Ready is held low only while reset is asserted; the input never backpressures otherwise.
   assign s_axis_tready = axi_resetn;

   assign w_dst   = s_axis_tuser[DST_POS +: NUM_QUEUES];
   assign w_admit = (w_dst != '0) && ((w_dst & ~w_room) == '0);
   assign w_first = (r_state == IDLE) && s_axis_tvalid;
   assign w_din   = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};

   always_comb begin
      w_wr_en = '0;
      case (r_state)
         IDLE: begin
            if (s_axis_tvalid && w_admit) begin
               w_wr_en = w_dst;
            end
         end
         WRITE: begin
            if (s_axis_tvalid) begin
               w_wr_en = r_sel;
            end
         end
         default: w_wr_en = '0;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         r_state <= IDLE;
         r_sel   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (s_axis_tvalid) begin
                  if (w_admit) begin
                     r_sel   <= w_dst;
                     r_state <= s_axis_tlast ? IDLE : WRITE;
                  end else begin
                     r_state <= s_axis_tlast ? IDLE : DROP;
                  end
               end
            end
            WRITE, DROP: begin
               if (s_axis_tvalid && s_axis_tlast) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
      // Admission needs room for a worst-case packet, judged on this cycle's occupancy.
      assign w_room[g] = (CW'(QUEUE_DEPTH) - w_count[g]) >= CW'(MAX_PKT_WORDS);

      nf10_oq_fifo #(
         .WIDTH (WW),
         .DEPTH (QUEUE_DEPTH)
      ) u_fifo (
         .i_clk   (axi_aclk),
         .i_rst_n (axi_resetn),
         .i_wr_en (w_wr_en[g]),
         .i_din   (w_din),
         .i_rd_en (m_axis_tready[g]),
         .o_dout  (w_dout[g]),
         .o_valid (w_valid[g]),
         .o_count (w_count[g])
      );

      assign m_axis_tdata[g*DW +: DW] = w_dout[g][WW-1 -: DW];
      assign m_axis_tstrb[g*SW +: SW] = w_dout[g][UW+1 +: SW];
      assign m_axis_tuser[g*UW +: UW] = w_dout[g][1 +: UW];
      assign m_axis_tlast[g]          = w_dout[g][0];
      assign m_axis_tvalid[g]         = w_valid[g];
   end

`ifdef OQ_STATS_EN
   for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_stats
      logic [OQ_CNT_W-1:0] r_enq_cnt;
      logic [OQ_CNT_W-1:0] r_drop_cnt;

      always_ff @(posedge axi_aclk) begin
         if (!axi_resetn) begin
            r_enq_cnt  <= '0;
            r_drop_cnt <= '0;
         end else if (w_first && w_dst[g]) begin
            if (w_admit) begin
               r_enq_cnt <= oq_sat_inc(r_enq_cnt);
            end else begin
               r_drop_cnt <= oq_sat_inc(r_drop_cnt);
            end
         end
      end

      assign pkt_enq_cnt[g*OQ_CNT_W +: OQ_CNT_W]  = r_enq_cnt;
      assign pkt_drop_cnt[g*OQ_CNT_W +: OQ_CNT_W] = r_drop_cnt;
   end
`endif

endmodule

// File: tb/tb_nf10_param_output_queues.sv
// Directed bench for nf10_param_output_queues: unicast, multicast, admission drops, streaming, reset.
module tb_nf10_param_output_queues;

   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = DW / 8;
   localparam int unsigned UW  = 32;
   localparam int unsigned NQ  = 5;
   localparam int unsigned QD  = 64;
   localparam int unsigned MPW = 48;
   localparam int unsigned DP  = 24;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DW-1:0]     s_tdata;
   logic [SW-1:0]     s_tstrb;
   logic [UW-1:0]     s_tuser;
   logic              s_tvalid;
   logic              s_tlast;
   logic              s_tready;
   logic [NQ*DW-1:0]  m_tdata;
   logic [NQ*SW-1:0]  m_tstrb;
   logic [NQ*UW-1:0]  m_tuser;
   logic [NQ-1:0]     m_tvalid;
   logic [NQ-1:0]     m_tready;
   logic [NQ-1:0]     m_tlast;
`ifdef OQ_STATS_EN
   logic [NQ*32-1:0]  drop_cnt;
   logic [NQ*32-1:0]  enq_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   nf10_param_output_queues #(
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .NUM_QUEUES           (NQ),
      .QUEUE_DEPTH          (QD),
      .MAX_PKT_WORDS        (MPW),
      .DST_POS              (DP)
   ) dut (
      .axi_aclk      (clk),
      .axi_resetn    (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tstrb  (s_tstrb),
      .s_axis_tuser  (s_tuser),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tstrb  (m_tstrb),
      .m_axis_tuser  (m_tuser),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast)
`ifdef OQ_STATS_EN
      ,
      .pkt_drop_cnt  (drop_cnt),
      .pkt_enq_cnt   (enq_cnt)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [UW-1:0] mk_user(input logic [31:0] d, input logic [NQ-1:0] dst);
      logic [UW-1:0] u;
      u             = '0;
      u[23:0]       = d[23:0];
      u[DP +: NQ]   = dst;
      return u;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d, input logic [NQ-1:0] dst, input logic last);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tstrb  = d[3:0];
      s_tuser  = mk_user(d, dst);
      s_tlast  = last;
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] base, input int n, input logic [NQ-1:0] dst);
      for (int k = 0; k < n; k++) begin
         beat(base + 32'(k), dst, k == n - 1);
      end
   endtask

   // Pops queue q until empty; word k must be base+k, tlast on the final word and on mid_last.
   task automatic drain(input int q, input logic [31:0] base, input int n, input int mid_last,
                        input string tag);
      int cnt;
      cnt         = 0;
      m_tready[q] = 1'b1;
      while (m_tvalid[q] && cnt < n + 8) begin
         if (cnt < n) begin
            check_eq({tag, "_data"}, m_tdata[q*DW +: DW], base + 32'(cnt));
            check_eq({tag, "_last"}, m_tlast[q], (cnt == n - 1) || (cnt == mid_last));
         end
         cnt++;
         tick();
      end
      m_tready[q] = 1'b0;
      check_eq({tag, "_words"}, cnt, n);
   endtask

`ifdef OQ_STATS_EN
   function automatic logic [31:0] cnt_of(input logic [NQ*32-1:0] v, input int q);
      return v[q*32 +: 32];
   endfunction
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] expq[$];
      int          nrecv;
      int          guard;

      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      s_tstrb  = '0;
      s_tuser  = '0;
      m_tready = '0;
      tick();
      tick();
      check_eq("rst_s_tready", s_tready, 1'b0);
      check_eq("rst_tvalid", m_tvalid, '0);
      check_eq("rst_tlast", m_tlast, '0);
      rst_n = 1'b1;
      #1;
      check_eq("s_tready_up", s_tready, 1'b1);
`ifdef OQ_STATS_EN
      check_eq("rst_enq_cnt", enq_cnt, '0);
      check_eq("rst_drop_cnt", drop_cnt, '0);
`endif

      // Unicast 4-beat packet to queue 1.
      beat(32'h101, 5'b00010, 1'b0);
      check_eq("uc_first_valid", m_tvalid, 5'b00010);
      check_eq("uc_first_data", m_tdata[1*DW +: DW], 32'h101);
      check_eq("uc_first_strb", m_tstrb[1*SW +: SW], 4'h1);
      check_eq("uc_first_user", m_tuser[1*UW +: UW], mk_user(32'h101, 5'b00010));
      beat(32'h102, 5'b00010, 1'b0);
      beat(32'h103, 5'b00010, 1'b0);
      beat(32'h104, 5'b00010, 1'b1);
      check_eq("uc_valid", m_tvalid, 5'b00010);
      drain(1, 32'h101, 4, -1, "uc");
`ifdef OQ_STATS_EN
      check_eq("uc_enq1", cnt_of(enq_cnt, 1), 1);
`endif

      // Multicast to queues 0, 2, 4.
      send_pkt(32'h501, 2, 5'b10101);
      check_eq("mc_valid", m_tvalid, 5'b10101);
      m_tready = 5'b10101;
      for (int k = 0; k < 2; k++) begin
         for (int q = 0; q < NQ; q++) begin
            if (q % 2 == 0) begin
               check_eq("mc_data", m_tdata[q*DW +: DW], 32'h501 + 32'(k));
               check_eq("mc_last", m_tlast[q], k == 1);
            end
         end
         tick();
      end
      m_tready = '0;
      check_eq("mc_empty", m_tvalid, '0);

      // Queue 0 holds 20 words: free 44 < 48, next packet is dropped whole.
      send_pkt(32'h100, 20, 5'b00001);
      for (int k = 0; k < 3; k++) begin
         beat(32'h1F0 + 32'(k), 5'b00001, k == 2);
         check_eq("drop_s_tready", s_tready, 1'b1);
      end
`ifdef OQ_STATS_EN
      check_eq("drop_cnt0", cnt_of(drop_cnt, 0), 1);
      check_eq("drop_enq0", cnt_of(enq_cnt, 0), 2);
`endif
      drain(0, 32'h100, 20, -1, "drop_q0");

      // Multicast to 0 and 1 with queue 1 short of room: dropped from both.
      send_pkt(32'h600, 20, 5'b00010);
      send_pkt(32'h6F0, 2, 5'b00011);
      check_eq("mcdrop_q0_empty", m_tvalid[0], 1'b0);
`ifdef OQ_STATS_EN
      check_eq("mcdrop_cnt0", cnt_of(drop_cnt, 0), 2);
      check_eq("mcdrop_cnt1", cnt_of(drop_cnt, 1), 1);
`endif
      drain(1, 32'h600, 20, -1, "mcdrop_q1");

      // Admission boundary: 16 queued leaves exactly 48 free, 17 leaves 47.
      send_pkt(32'h700, 16, 5'b00010);
      beat(32'h710, 5'b00010, 1'b1);
      beat(32'h711, 5'b00010, 1'b1);
`ifdef OQ_STATS_EN
      check_eq("bound_enq1", cnt_of(enq_cnt, 1), 4);
      check_eq("bound_drop1", cnt_of(drop_cnt, 1), 2);
`endif
      drain(1, 32'h700, 17, 15, "bound");

      // Single-beat packets every cycle to queue 3 with tready toggling.
      nrecv = 0;
      for (int c = 0; c < 24; c++) begin
         m_tready[3] = c[0];
         if (m_tvalid[3] && m_tready[3]) begin
            check_eq("stream_data", m_tdata[3*DW +: DW], expq.pop_front());
            nrecv++;
         end
         expq.push_back(32'h400 + 32'(c));
         beat(32'h400 + 32'(c), 5'b01000, 1'b1);
      end
      m_tready[3] = 1'b1;
      guard       = 0;
      while (expq.size() > 0 && guard < 100) begin
         if (m_tvalid[3]) begin
            check_eq("stream_data", m_tdata[3*DW +: DW], expq.pop_front());
            nrecv++;
         end
         guard++;
         tick();
      end
      m_tready[3] = 1'b0;
      check_eq("stream_words", nrecv, 24);
      check_eq("stream_empty", m_tvalid[3], 1'b0);
`ifdef OQ_STATS_EN
      check_eq("stream_enq3", cnt_of(enq_cnt, 3), 24);
`endif

      // Reset during beat 2 of a 5-beat packet; the remaining beats form a new packet.
      beat(32'h301, 5'b00100, 1'b0);
      s_tvalid = 1'b1;
      s_tdata  = 32'h302;
      s_tstrb  = 4'h2;
      s_tuser  = mk_user(32'h302, 5'b00100);
      rst_n    = 1'b0;
      tick();
      s_tvalid = 1'b0;
      check_eq("midrst_tvalid", m_tvalid, '0);
      check_eq("midrst_s_tready", s_tready, 1'b0);
`ifdef OQ_STATS_EN
      check_eq("midrst_enq2", cnt_of(enq_cnt, 2), 0);
`endif
      rst_n = 1'b1;
      send_pkt(32'h303, 3, 5'b00100);
`ifdef OQ_STATS_EN
      check_eq("postrst_enq2", cnt_of(enq_cnt, 2), 1);
`endif
      drain(2, 32'h303, 3, -1, "postrst");
      check_eq("final_idle", m_tvalid, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
